data_memory_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the data_memory block. It shares the single memory between requester 0 (CPU load/store unit) and requester 1 (DMA/debug loader). It grants one requester at a time, drives the memory's address, write_data, mem_write and mem_read lines for a fixed access window, and captures read data. It returns a one-cycle completion pulse to the granted requester.

---
 rtl/data_memory_arbiter.sv | 118 +++++++++++
 tb/tb_data_memory_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter and access sequencer sharing one data_memory between the
// CPU load/store unit (port 0) and the DMA/debug loader (port 1).
module data_memory_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int ACCESS_CYCLES  = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [3:0] COUNT_INIT = 4'(ACCESS_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        count;
    logic              owner;
    logic              last_served;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              any_req;
    logic              winner;

    // On a tie, round-robin favours the port that was not served last.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_served;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    assign any_req = req0 | req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= 4'd0;
            owner       <= 1'b0;
            last_served <= 1'b1;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= winner;
                        lat_we    <= winner ? we1 : we0;
                        lat_addr  <= winner ? addr1 : addr0;
                        lat_wdata <= winner ? wdata1 : wdata0;
                        count     <= COUNT_INIT;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count == 4'd0) begin
                        if (!lat_we) begin
                            if (owner) begin
                                rdata1 <= mem_read_data;
                            end else begin
                                rdata0 <= mem_read_data;
                            end
                        end
                        state <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    last_served <= owner;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign busy           = (state != IDLE);
    assign gnt0           = busy && !owner;
    assign gnt1           = busy && owner;
    assign done0          = (state == DONE) && !owner;
    assign done1          = (state == DONE) && owner;
    assign mem_write      = (state == ACCESS) && lat_we;
    assign mem_read       = (state == ACCESS) && !lat_we;
    assign mem_address    = lat_addr;
    assign mem_write_data = lat_wdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: one round-robin instance (ACCESS_CYCLES=1) and
// one fixed-priority instance (ACCESS_CYCLES=3), each with its own memory.
module tb_data_memory_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0 [2];
    logic       we0 [2];
    logic [7:0] addr0 [2];
    logic [7:0] wdata0 [2];
    logic       gnt0 [2];
    logic       done0 [2];
    logic [7:0] rdata0 [2];
    logic       req1 [2];
    logic       we1 [2];
    logic [7:0] addr1 [2];
    logic [7:0] wdata1 [2];
    logic       gnt1 [2];
    logic       done1 [2];
    logic [7:0] rdata1 [2];
    logic       busy [2];
    logic [7:0] mem_address [2];
    logic [7:0] mem_write_data [2];
    logic       mem_write [2];
    logic       mem_read [2];
    logic [7:0] mem_read_data [2];

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    // Reference model: expected memory contents, per-port read data, last served port.
    logic [7:0] ref_mem [2][256];
    logic [7:0] ref_rd [2][2];
    bit         last_srv [2];

    int tests_run;
    int tests_failed;
    int excl_viol [2];

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(1), .FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .gnt0(gnt0[0]), .done0(done0[0]), .rdata0(rdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .gnt1(gnt1[0]), .done1(done1[0]), .rdata1(rdata1[0]),
        .busy(busy[0]), .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
        .mem_write(mem_write[0]), .mem_read(mem_read[0]), .mem_read_data(mem_read_data[0])
    );

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(3), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .gnt0(gnt0[1]), .done0(done0[1]), .rdata0(rdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .gnt1(gnt1[1]), .done1(done1[1]), .rdata1(rdata1[1]),
        .busy(busy[1]), .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
        .mem_write(mem_write[1]), .mem_read(mem_read[1]), .mem_read_data(mem_read_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data_memory for each instance: clocked write, combinational read.
    always @(posedge clk) begin
        if (mem_write[0]) mem_a[mem_address[0]] = mem_write_data[0];
        if (mem_write[1]) mem_b[mem_address[1]] = mem_write_data[1];
    end
    assign mem_read_data[0] = mem_a[mem_address[0]];
    assign mem_read_data[1] = mem_b[mem_address[1]];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_write[i] && mem_read[i]) excl_viol[i]++;
        end
    end

    function automatic logic [46:0] all_outs(input int i);
        return {gnt0[i], gnt1[i], done0[i], done1[i], busy[i], mem_write[i], mem_read[i],
                rdata0[i], rdata1[i], mem_address[i], mem_write_data[i]};
    endfunction

    task automatic reset_model;
        for (int i = 0; i < 2; i++) begin
            ref_rd[i][0] = 8'd0;
            ref_rd[i][1] = 8'd0;
            last_srv[i]  = 1'b1;
        end
    endtask

    // Issues one transaction at a negedge and observes it until its done pulse.
    task automatic run_txn(input int inst, input bit port, input bit we, input logic [7:0] addr,
                           input logic [7:0] wd, output int lat, output int nw, output int nr,
                           output bit path_ok, output logic [7:0] rd, output bit done_once);
        lat = 0; nw = 0; nr = 0; path_ok = 1'b1; done_once = 1'b1;
        if (port) begin
            req1[inst] = 1'b1; we1[inst] = we; addr1[inst] = addr; wdata1[inst] = wd;
        end else begin
            req0[inst] = 1'b1; we0[inst] = we; addr0[inst] = addr; wdata0[inst] = wd;
        end
        forever begin
            @(negedge clk);
            lat++;
            if (mem_write[inst]) begin
                nw++;
                if (mem_address[inst] !== addr || mem_write_data[inst] !== wd) path_ok = 1'b0;
            end
            if (mem_read[inst]) begin
                nr++;
                if (mem_address[inst] !== addr) path_ok = 1'b0;
            end
            if (port ? (gnt1[inst] !== 1'b1 || gnt0[inst] !== 1'b0 || done0[inst] !== 1'b0)
                     : (gnt0[inst] !== 1'b1 || gnt1[inst] !== 1'b0 || done1[inst] !== 1'b0))
                path_ok = 1'b0;
            if ((port ? done1[inst] : done0[inst]) === 1'b1) break;
            if (lat >= 30) begin
                lat = -1;
                break;
            end
        end
        rd = port ? rdata1[inst] : rdata0[inst];
        req0[inst] = 1'b0;
        req1[inst] = 1'b0;
        last_srv[inst] = port;
        @(negedge clk);
        if (done0[inst] !== 1'b0 || done1[inst] !== 1'b0) done_once = 1'b0;
    endtask

    task automatic test_reset;
        logic [46:0] o;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            o = all_outs(i);
            tests_run++;
            if (o !== 47'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_hold inst%0d: outputs=%h required 0", i, o);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                o = all_outs(i);
                tests_run++;
                if (o !== 47'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL idle_after_reset inst%0d cyc%0d: outputs=%h required 0", i, c, o);
                end
            end
        end
    endtask

    task automatic test_single_write_read;
        int lat, nw, nr;
        bit ok, d1;
        logic [7:0] rd;
        run_txn(0, 1'b0, 1'b1, 8'd10, 8'd55, lat, nw, nr, ok, rd, d1);
        ref_mem[0][10] = 8'd55;
        tests_run++;
        if (lat !== 2 || nw !== 1 || nr !== 0 || !ok || !d1) begin
            tests_failed++;
            $display("[TB] FAIL p0_write: lat=%0d nw=%0d nr=%0d path=%0d once=%0d required 2 1 0 1 1", lat, nw, nr, ok, d1);
        end
        run_txn(0, 1'b0, 1'b0, 8'd10, 8'd0, lat, nw, nr, ok, rd, d1);
        ref_rd[0][0] = ref_mem[0][10];
        tests_run++;
        if (lat !== 2 || nw !== 0 || nr !== 1 || !ok || !d1 || rd !== 8'd55) begin
            tests_failed++;
            $display("[TB] FAIL p0_read: lat=%0d nw=%0d nr=%0d path=%0d rd=%0d required 2 0 1 1 55", lat, nw, nr, ok, rd);
        end
        tests_run++;
        if (rdata1[0] !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL p1_untouched: rdata1=%0d required 0", rdata1[0]);
        end
    endtask

    task automatic test_port1;
        int lat, nw, nr;
        bit ok, d1;
        logic [7:0] rd;
        run_txn(0, 1'b1, 1'b1, 8'd20, 8'd100, lat, nw, nr, ok, rd, d1);
        ref_mem[0][20] = 8'd100;
        tests_run++;
        if (lat !== 2 || nw !== 1 || !ok || !d1 || rdata1[0] !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL p1_write: lat=%0d nw=%0d path=%0d rdata1=%0d required 2 1 1 0", lat, nw, ok, rdata1[0]);
        end
        run_txn(0, 1'b1, 1'b0, 8'd20, 8'd0, lat, nw, nr, ok, rd, d1);
        ref_rd[0][1] = ref_mem[0][20];
        tests_run++;
        if (lat !== 2 || nr !== 1 || !ok || rd !== ref_rd[0][1]) begin
            tests_failed++;
            $display("[TB] FAIL p1_read20: lat=%0d nr=%0d path=%0d rd=%0d required 2 1 1 %0d", lat, nr, ok, rd, ref_rd[0][1]);
        end
        run_txn(0, 1'b1, 1'b0, 8'd30, 8'd0, lat, nw, nr, ok, rd, d1);
        ref_rd[0][1] = ref_mem[0][30];
        tests_run++;
        if (rd !== 8'd0 || rdata0[0] !== 8'd55) begin
            tests_failed++;
            $display("[TB] FAIL p1_read30: rdata1=%0d rdata0=%0d required 0 55", rd, rdata0[0]);
        end
    endtask

    task automatic test_random;
        int lat, nw, nr;
        bit ok, d1, port, we;
        logic [7:0] rd, a, d, other;
        for (int t = 0; t < 24; t++) begin
            port = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            a    = 8'($urandom_range(64, 127));
            d    = 8'($urandom);
            run_txn(0, port, we, a, d, lat, nw, nr, ok, rd, d1);
            if (we) ref_mem[0][a] = d;
            else    ref_rd[0][port] = ref_mem[0][a];
            other = port ? rdata0[0] : rdata1[0];
            tests_run++;
            if (lat !== 2 || nw !== int'(we) || nr !== int'(!we) || !ok || !d1 ||
                (port ? rdata1[0] : rdata0[0]) !== ref_rd[0][port] || other !== ref_rd[0][!port]) begin
                tests_failed++;
                $display("[TB] FAIL random_txn%0d p%0d we%0d a%0d: lat=%0d nw=%0d nr=%0d path=%0d rd=%0d other=%0d required rd=%0d other=%0d",
                         t, port, we, a, lat, nw, nr, ok, rd, other, ref_rd[0][port], ref_rd[0][!port]);
            end
        end
    endtask

    task automatic test_round_robin;
        int n, cyc, last_cyc, both_gnt;
        bit p, exp_p;
        logic [7:0] exp_rd, got;
        exp_p = !last_srv[0];
        excl_viol[0] = 0;
        n = 0; cyc = 0; last_cyc = 0; both_gnt = 0;
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'd10;
        req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 8'd20;
        while (n < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt0[0] && gnt1[0]) both_gnt++;
            if (done0[0] || done1[0]) begin
                p      = done1[0];
                got    = p ? rdata1[0] : rdata0[0];
                exp_rd = ref_mem[0][p ? 20 : 10];
                tests_run++;
                if (p !== exp_p || (cyc - last_cyc) !== (n == 0 ? 2 : 3) || got !== exp_rd) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_grant%0d: port=%0d gap=%0d rd=%0d required port=%0d gap=%0d rd=%0d",
                             n, p, cyc - last_cyc, got, exp_p, (n == 0 ? 2 : 3), exp_rd);
                end
                ref_rd[0][p] = exp_rd;
                last_srv[0]  = p;
                exp_p        = !p;
                last_cyc     = cyc;
                n++;
                if (n == 6) begin
                    req0[0] = 1'b0;
                    req1[0] = 1'b0;
                end
            end
        end
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (n !== 6 || both_gnt !== 0 || excl_viol[0] !== 0 || busy[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rr_summary: dones=%0d both_gnt=%0d excl=%0d busy=%0d required 6 0 0 0",
                     n, both_gnt, excl_viol[0], busy[0]);
        end
    endtask

    task automatic test_fixed_priority;
        int lat, nw, nr, n, cyc, last_cyc, g1, reads;
        bit ok, d1;
        logic [7:0] rd, d;
        d = 8'($urandom_range(1, 255));
        run_txn(1, 1'b0, 1'b1, 8'd5, d, lat, nw, nr, ok, rd, d1);
        ref_mem[1][5] = d;
        tests_run++;
        if (lat !== 4 || nw !== 3 || nr !== 0 || !ok || !d1) begin
            tests_failed++;
            $display("[TB] FAIL fp_write: lat=%0d nw=%0d nr=%0d path=%0d once=%0d required 4 3 0 1 1", lat, nw, nr, ok, d1);
        end
        run_txn(1, 1'b1, 1'b1, 8'd6, ~d, lat, nw, nr, ok, rd, d1);
        ref_mem[1][6] = ~d;
        tests_run++;
        if (lat !== 4 || nw !== 3 || !ok || !d1) begin
            tests_failed++;
            $display("[TB] FAIL fp_p1_write: lat=%0d nw=%0d path=%0d required 4 3 1", lat, nw, ok);
        end
        excl_viol[1] = 0;
        n = 0; cyc = 0; last_cyc = 0; g1 = 0; reads = 0;
        req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 8'd5;
        req1[1] = 1'b1; we1[1] = 1'b0; addr1[1] = 8'd6;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt1[1] || done1[1]) g1++;
            if (mem_read[1]) reads++;
            if (done0[1]) begin
                tests_run++;
                if ((cyc - last_cyc) !== (n == 0 ? 4 : 5) || rdata0[1] !== ref_mem[1][5]) begin
                    tests_failed++;
                    $display("[TB] FAIL fp_grant%0d: gap=%0d rd=%0d required gap=%0d rd=%0d",
                             n, cyc - last_cyc, rdata0[1], (n == 0 ? 4 : 5), ref_mem[1][5]);
                end
                ref_rd[1][0] = ref_mem[1][5];
                last_cyc = cyc;
                n++;
                if (n == 4) begin
                    req0[1] = 1'b0;
                    req1[1] = 1'b0;
                end
            end
        end
        req0[1] = 1'b0;
        req1[1] = 1'b0;
        last_srv[1] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (n !== 4 || g1 !== 0 || reads !== 12 || excl_viol[1] !== 0) begin
            tests_failed++;
            $display("[TB] FAIL fp_summary: dones=%0d gnt1_cycles=%0d read_cycles=%0d excl=%0d required 4 0 12 0",
                     n, g1, reads, excl_viol[1]);
        end
    endtask

    task automatic test_reset_mid_access;
        int lat, nw, nr, seen;
        bit ok, d1;
        logic [7:0] rd;
        req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 8'd40; wdata1[1] = 8'd77;
        repeat (2) @(negedge clk);
        tests_run++;
        if (mem_write[1] !== 1'b1 || mem_address[1] !== 8'd40) begin
            tests_failed++;
            $display("[TB] FAIL mid_access_setup: mem_write=%0d addr=%0d required 1 40", mem_write[1], mem_address[1]);
        end
        req1[1] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_write[1] !== 1'b0 || gnt1[1] !== 1'b0 || busy[1] !== 1'b0 || rdata0[0] !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: mem_write=%0d gnt1=%0d busy=%0d rdata0=%0d required 0 0 0 0",
                     mem_write[1], gnt1[1], busy[1], rdata0[0]);
        end
        reset_model();
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done1[1]) seen++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done1[1] || busy[1]) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("[TB] FAIL lost_txn: done1/busy cycles=%0d required 0", seen);
        end
        run_txn(0, 1'b0, 1'b0, 8'd10, 8'd0, lat, nw, nr, ok, rd, d1);
        ref_rd[0][0] = ref_mem[0][10];
        tests_run++;
        if (lat !== 2 || !ok || rd !== 8'd55 || rdata1[0] !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL read_after_reset: lat=%0d path=%0d rdata0=%0d rdata1=%0d required 2 1 55 0",
                     lat, ok, rd, rdata1[0]);
        end
        run_txn(1, 1'b0, 1'b0, 8'd5, 8'd0, lat, nw, nr, ok, rd, d1);
        tests_run++;
        if (lat !== 4 || nr !== 3 || !ok || rd !== ref_mem[1][5]) begin
            tests_failed++;
            $display("[TB] FAIL fp_read_after_reset: lat=%0d nr=%0d path=%0d rd=%0d required 4 3 1 %0d",
                     lat, nr, ok, rd, ref_mem[1][5]);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 2; i++) begin
            req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = 8'd0; wdata0[i] = 8'd0;
            req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = 8'd0; wdata1[i] = 8'd0;
            excl_viol[i] = 0;
        end
        for (int a = 0; a < 256; a++) begin
            mem_a[a] = 8'd0;
            mem_b[a] = 8'd0;
            ref_mem[0][a] = 8'd0;
            ref_mem[1][a] = 8'd0;
        end
        reset_model();
        rst_n = 1'b0;
        test_reset();
        test_single_write_read();
        test_port1();
        test_random();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
